// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter register and fetch-address sequencer for the MIPS core.
// It advances the fetch address by 4 and applies a resolved control-transfer
// target with one architectural branch-delay slot. A committed transfer to
// HALT_ADDR stops the CPU. A misaligned target also stops the CPU and sets a
// sticky error flag.
//
// Ports
//   clk          in   rising-edge system clock
//   reset_n      in   asynchronous active-low reset
//   stall        in   1 = hold all state this cycle
//   jump_en      in   current instruction is a taken transfer (sampled on advance)
//   jump_target  in   resolved transfer target, valid with jump_en
//   pc           out  current fetch address (registered)
//   pc_plus4     out  pc + 4, wraps mod 2^32
//   pc_4msb      out  pc_plus4[31:28], used to form J/JAL targets
//   link_addr    out  pc + 8, wraps mod 2^32 (link register value)
//   delay_slot   out  1 = current pc is a branch delay slot
//   active       out  1 = CPU running, 0 once halted
//   addr_error   out  sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
   parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [3:0]  pc_4msb,
   output logic [31:0] link_addr,
   output logic        delay_slot,
   output logic        active,
   output logic        addr_error
);

   typedef enum logic [1:0] {
      SEQ    = 2'd0,
      DELAY  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc_next;
   logic [31:0] target, target_next;
   logic        addr_error_next;
   logic        advance;

   // Address arithmetic wraps naturally in 32 bits; wrap-around is legal.
   assign pc_plus4   = pc + 32'd4;
   assign link_addr  = pc + 32'd8;
   assign pc_4msb    = pc_plus4[31:28];
   assign delay_slot = (state == DELAY);
   assign active     = (state != HALTED);
   assign advance    = active & ~stall;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      target_next     = target;
      addr_error_next = addr_error;

      if (advance) begin
         unique case (state)
            SEQ: begin
               if (jump_en) begin
                  if (jump_target[1:0] != 2'b00) begin
                     // Misaligned target: stop at the jump instruction itself.
                     addr_error_next = 1'b1;
                     state_next      = HALTED;
                  end else begin
                     // Capture the target now; the delay slot executes first.
                     target_next = jump_target;
                     pc_next     = pc_plus4;
                     state_next  = DELAY;
                  end
               end else begin
                  pc_next = pc_plus4;
               end
            end
            DELAY: begin
               // A transfer in the delay slot is ignored: the first target wins.
               pc_next    = target;
               state_next = (target == HALT_ADDR) ? HALTED : SEQ;
            end
            HALTED: begin
               // Unreachable while advancing; everything stays frozen.
            end
            default: begin
               state_next = HALTED;
            end
         endcase
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SEQ;
         pc         <= RESET_VECTOR;
         target     <= '0;
         addr_error <= 1'b0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         target     <= target_next;
         addr_error <= addr_error_next;
      end
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and fetch-address sequencer for the multicycle/pipelined MIPS core.
- Consumes the resolved control-transfer target (J/JAL target formed from pc_4msb plus shifted immediate, JR/JALR register target, taken-branch target).
- Applies the target with exact MIPS branch-delay-slot semantics.
- Supplies pc_4msb back to the jump target formation logic and drives CPU termination on a jump to the halt address.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
HALT_ADDR, 32'h00000000, committing a transfer to this address terminates execution

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
stall  input  1  1 = hold PC this cycle (memory wait / multicycle step not complete)
jump_en  input  1  instruction at current pc is a taken transfer; sampled only when advancing
jump_target  input  32  resolved target address, valid with jump_en
pc  output  32  current fetch address (registered)
pc_plus4  output  32  pc + 4, combinational, mod 2^32
pc_4msb  output  4  pc_plus4[31:28]
link_addr  output  32  pc + 8, mod 2^32 (JAL/JALR/BxxAL link value)
delay_slot  output  1  1 = current pc is a branch delay slot
active  output  1  1 = CPU running; 0 after halt
addr_error  output  1  sticky; set on misaligned target

Behaviour:
- Reset (async, reset_n=0): pc=RESET_VECTOR, state=SEQ, pending target cleared, delay_slot=0, active=1, addr_error=0. Release is synchronous to the next clk edge.
- advance = active & ~stall. When advance=0, all state holds and jump_en is ignored.
- States: SEQ, DELAY, HALTED. delay_slot = (state==DELAY).
- SEQ, advance, jump_en=0: pc <= pc+4.
- SEQ, advance, jump_en=1:
  - If jump_target[1:0]!=0: addr_error<=1, state<=HALTED, active<=0, pc holds.
  - Otherwise: latch target, pc <= pc+4 (delay slot), state<=DELAY.
- DELAY, advance:
  - pc <= latched target.
  - If latched target==HALT_ADDR: state<=HALTED, active<=0.
  - Otherwise state<=SEQ.
  - jump_en asserted in DELAY (transfer in delay slot, architecturally undefined) is ignored. The first target wins.
- HALTED: pc, addr_error and outputs frozen. Only reset leaves HALTED.
- Latency: the target appears on pc exactly two advancing cycles after the jump_en cycle. Stall cycles in between extend this 1:1.
- Stall in DELAY: the latched target is retained indefinitely.
- Wrap-around: pc+4 and pc+8 wrap modulo 2^32, no error (e.g. pc=FFFFFFFC gives pc_plus4=00000000).
- A sequential pc reaching HALT_ADDR by increment does not halt. Only a committed transfer halts.
- Reset mid-DELAY discards the pending target.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, release with stall=0 -> pc=BFC00000, then BFC00004, BFC00008; active=1, delay_slot=0, pc_4msb=B, link_addr=pc+8.
- Jump with delay slot: at pc=BFC00010 assert jump_en, jump_target=BFC00100 -> next pc=BFC00014 with delay_slot=1, then pc=BFC00100 with delay_slot=0, then BFC00104.
- Stall interaction: jump_en at pc=BFC00020 (target BFC00200), stall=1 for 3 cycles during DELAY -> pc holds BFC00024 and delay_slot=1 throughout, then pc=BFC00200. Separately, jump_en asserted only while stall=1 -> ignored, pc unchanged.
- Halt: jump_en, jump_target=00000000 at pc=BFC00040 -> pc=BFC00044 (delay slot executes), then pc=00000000 and active=0. Further cycles and jump_en have no effect.
- Misaligned target: jump_en, jump_target=BFC00102 -> addr_error=1, active=0, pc frozen at jump pc. Pulsing reset_n=0 mid-operation -> pc=BFC00000, addr_error=0, active=1.
- Jump in delay slot plus wrap: second jump_en during DELAY -> ignored, first target taken. Jump to FFFFFFFC -> pc_plus4=00000000, link_addr=00000004, next sequential pc=00000000 with active still 1.
